// File: rtl/vending_pkg.sv
// vending_pkg: shared coin/item/change/plan codes and buyer state encoding.
package vending_pkg;

    localparam logic [1:0] MONEY_NONE = 2'b00;
    localparam logic [1:0] MONEY_10   = 2'b01;
    localparam logic [1:0] MONEY_50   = 2'b10;

    localparam logic [1:0] ITEM_NONE  = 2'b00;
    localparam logic [1:0] ITEM_20    = 2'b01;
    localparam logic [1:0] ITEM_50    = 2'b10;

    localparam logic [1:0] CHG_0      = 2'b00;
    localparam logic [1:0] CHG_10     = 2'b01;
    localparam logic [1:0] CHG_30     = 2'b10;
    localparam logic [1:0] CHG_40     = 2'b11;

    localparam logic [1:0] PLAN_10_10 = 2'b00;
    localparam logic [1:0] PLAN_10_50 = 2'b01;
    localparam logic [1:0] PLAN_50    = 2'b10;
    localparam logic [1:0] PLAN_BAD   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_COIN1, S_GAP1, S_COIN2, S_GAP2, S_SEL, S_GAP3, S_WAIT, S_DONE
    } buyer_state_t;

endpackage

// File: rtl/vending_buyer_if.sv
// vending_buyer_if: host request/result and vending_machine coin/select signals.
// VENDING_BUYER_STATS_EN adds the buy_count/err_count statistics.
interface vending_buyer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_plan;
    logic [1:0] req_item;
    logic [1:0] money;
    logic [1:0] select;
    logic [1:0] item;
    logic [1:0] change;
    logic       done;
    logic [1:0] got_item;
    logic [1:0] got_change;
    logic       err;
`ifdef VENDING_BUYER_STATS_EN
    logic [7:0] buy_count;
    logic [7:0] err_count;
`endif

    modport slave (
        input  req_valid, req_plan, req_item, item, change,
        output req_ready, money, select, done, got_item, got_change, err
`ifdef VENDING_BUYER_STATS_EN
        , buy_count, err_count
`endif
    );

    modport master (
        output req_valid, req_plan, req_item, item, change,
        input  req_ready, money, select, done, got_item, got_change, err
`ifdef VENDING_BUYER_STATS_EN
        , buy_count, err_count
`endif
    );
endinterface

// File: rtl/vending_expect.sv
// vending_expect: decodes a plan/item pair into legality and the expected item/change.
module vending_expect
    import vending_pkg::*;
(
    input  logic [1:0] i_plan,
    input  logic [1:0] i_item,
    output logic [1:0] o_item,
    output logic [1:0] o_change,
    output logic       o_legal
);
    assign o_legal  = i_plan == PLAN_10_10 ||
                      (i_plan != PLAN_BAD && (i_item == ITEM_20 || i_item == ITEM_50));
    assign o_item   = i_plan == PLAN_10_10 ? ITEM_20 : i_item;
    assign o_change = i_plan == PLAN_10_10 ? CHG_0 :
                      i_plan == PLAN_10_50 ? (i_item == ITEM_20 ? CHG_40 : CHG_10) :
                                             (i_item == ITEM_20 ? CHG_30 : CHG_0);
endmodule

// File: rtl/vending_buyer.sv
// vending_buyer: drives money/select pulses to vending_machine and checks its response.
// VENDING_BUYER_STATS_EN adds saturating buy_count/err_count outputs.
module vending_buyer
    import vending_pkg::*;
#(
    parameter int GAP     = 3,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    vending_buyer_if.slave bus
);
    localparam int CW = $clog2((GAP > TIMEOUT ? GAP : TIMEOUT) + 2);

    buyer_state_t  r_state, w_next;
    logic [1:0]    r_plan, r_item, r_money, r_select, r_got_item, r_got_change;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [1:0]    w_plan, w_req_item, w_exp_item, w_exp_change;
    logic          w_legal, w_accept, w_last, w_post, w_gap, w_cap, w_tmo, w_gap_end, w_pulse;

    // In IDLE the decoder looks at the incoming request so legality is known at accept.
    assign w_plan     = r_state == S_IDLE ? bus.req_plan : r_plan;
    assign w_req_item = r_state == S_IDLE ? bus.req_item : r_item;

    vending_expect u_expect (
        .i_plan   (w_plan),
        .i_item   (w_req_item),
        .o_item   (w_exp_item),
        .o_change (w_exp_change),
        .o_legal  (w_legal)
    );

    assign w_accept  = r_state == S_IDLE && bus.req_valid;
    assign w_last    = r_state == S_SEL || (r_state == S_COIN2 && r_plan == PLAN_10_10);
    assign w_post    = w_last || r_state == S_GAP3 || r_state == S_WAIT ||
                       (r_state == S_GAP2 && r_plan == PLAN_10_10);
    assign w_gap     = r_state == S_GAP1 || r_state == S_GAP2 || r_state == S_GAP3;
    assign w_cap     = (w_post || w_gap) && bus.item != ITEM_NONE;
    assign w_tmo     = w_post && r_cnt == CW'(TIMEOUT - 1);
    assign w_gap_end = r_cnt == CW'(GAP);
    assign w_pulse   = w_next == S_COIN1 || w_next == S_COIN2 || w_next == S_SEL;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !bus.req_valid ? S_IDLE : w_legal ? S_COIN1 : S_DONE;
            S_COIN1: w_next = S_GAP1;
            S_GAP1:  w_next = !w_gap_end ? S_GAP1 : r_plan == PLAN_50 ? S_SEL : S_COIN2;
            S_COIN2: w_next = S_GAP2;
            S_GAP2:  w_next = !w_gap_end ? S_GAP2 : r_plan == PLAN_10_10 ? S_WAIT : S_SEL;
            S_SEL:   w_next = S_GAP3;
            S_GAP3:  w_next = w_gap_end ? S_WAIT : S_GAP3;
            S_DONE:  w_next = S_IDLE;
            default: w_next = r_state;
        endcase
        if (w_cap || w_tmo) w_next = S_DONE;
    end

    // The counter restarts on every pulse, so it serves both gap timing and the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_plan       <= PLAN_10_10;
            r_item       <= ITEM_NONE;
            r_money      <= MONEY_NONE;
            r_select     <= ITEM_NONE;
            r_got_item   <= ITEM_NONE;
            r_got_change <= CHG_0;
            r_err        <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= (r_state == S_IDLE || w_pulse) ? '0 : r_cnt + 1'b1;
            r_money  <= w_next == S_COIN1 ? (w_plan == PLAN_50 ? MONEY_50 : MONEY_10) :
                        w_next == S_COIN2 ? (r_plan == PLAN_10_10 ? MONEY_10 : MONEY_50) :
                                            MONEY_NONE;
            r_select <= w_next == S_SEL ? r_item : ITEM_NONE;
            if (w_accept) begin
                r_plan       <= bus.req_plan;
                r_item       <= bus.req_item;
                r_got_item   <= ITEM_NONE;
                r_got_change <= CHG_0;
                r_err        <= !w_legal;
            end else if (w_cap) begin
                r_got_item   <= bus.item;
                r_got_change <= bus.change;
                r_err        <= bus.item != w_exp_item || bus.change != w_exp_change;
            end else if (w_tmo) begin
                r_err        <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = r_state == S_IDLE;
    assign bus.money      = r_money;
    assign bus.select     = r_select;
    assign bus.done       = r_state == S_DONE;
    assign bus.got_item   = r_got_item;
    assign bus.got_change = r_got_change;
    assign bus.err        = r_err;

`ifdef VENDING_BUYER_STATS_EN
    logic [7:0] r_buy_count, r_err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buy_count <= 8'd0;
            r_err_count <= 8'd0;
        end else if (r_state == S_DONE) begin
            if (r_err) r_err_count <= r_err_count == 8'hff ? r_err_count : r_err_count + 8'd1;
            else       r_buy_count <= r_buy_count == 8'hff ? r_buy_count : r_buy_count + 8'd1;
        end
    end

    assign bus.buy_count = r_buy_count;
    assign bus.err_count = r_err_count;
`endif
endmodule

// File: tb/tb_vending_buyer.sv
// tb_vending_buyer: drives vending_buyer against a behavioural vending machine model
// (normal, silent and wrong-change variants) and checks results against a purchase model.
module tb_vending_buyer;
    import vending_pkg::*;

    localparam int GAP      = 3;
    localparam int TIMEOUT  = 8;
    localparam int M_OK     = 0;
    localparam int M_SILENT = 1;
    localparam int M_WRONG  = 2;

    typedef struct {
        int         cyc;
        int         sel;
        logic [1:0] code;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vending_buyer_if bus ();

    vending_buyer #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         total = 0, bad = 0, cyc = 0, mode = M_OK, resp_cyc = -1;
    int         overlaps = 0, holds = 0;
    pulse_t     pq[$];
    int         m_credit = 0, m_dly = 0, m_price = 0;
    bit         m_pend = 0;
    logic [1:0] m_item = 2'b00, m_chg = 2'b00, prev_m = 2'b00, prev_s = 2'b00;

    function automatic logic [1:0] chg_code(input int amt);
        return amt == 10 ? CHG_10 : amt == 30 ? CHG_30 : amt == 40 ? CHG_40 : CHG_0;
    endfunction

    // Machine model and pulse monitor: credit accumulates, 20 auto-vends, select vends.
    initial begin
        bus.item   = ITEM_NONE;
        bus.change = CHG_0;
        forever begin
            pulse_t p;
            @(posedge clk);
            cyc++;
            #1;
            bus.item   = ITEM_NONE;
            bus.change = CHG_0;
            if (!rst_n) begin
                m_credit = 0;
                m_pend   = 0;
                prev_m   = 2'b00;
                prev_s   = 2'b00;
            end else begin
                if (bus.money != 2'b00 && bus.select != 2'b00) overlaps++;
                if ((bus.money != 2'b00 && prev_m != 2'b00) || (bus.select != 2'b00 && prev_s != 2'b00)) holds++;
                prev_m = bus.money;
                prev_s = bus.select;
                if (bus.money != 2'b00) begin
                    p.cyc = cyc; p.sel = 0; p.code = bus.money;
                    pq.push_back(p);
                end
                if (bus.select != 2'b00) begin
                    p.cyc = cyc; p.sel = 1; p.code = bus.select;
                    pq.push_back(p);
                end
                if (mode != M_SILENT) begin
                    if (bus.money != 2'b00) begin
                        m_credit += bus.money == MONEY_10 ? 10 : 50;
                        if (m_credit == 20) begin
                            m_pend = 1; m_item = ITEM_20; m_chg = CHG_0; m_credit = 0;
                            m_dly = $urandom_range(0, 2);
                        end
                    end
                    if (bus.select != 2'b00) begin
                        m_price = bus.select == ITEM_20 ? 20 : 50;
                        m_chg   = mode == M_WRONG ? CHG_10 : chg_code(m_credit - m_price);
                        m_item  = bus.select;
                        m_credit = 0;
                        m_pend  = 1;
                        m_dly   = $urandom_range(0, 2);
                    end
                end
                if (m_pend) begin
                    if (m_dly == 0) begin
                        bus.item   = m_item;
                        bus.change = m_chg;
                        resp_cyc   = cyc;
                        m_pend     = 0;
                    end else m_dly--;
                end
            end
        end
    end

    task automatic test_purchase(input logic [1:0] plan, input logic [1:0] item, input int md);
        bit         legal;
        int         paid, price, n, acc, dc, exp_dc;
        int         e_sel[3];
        logic [1:0] e_code[3];
        logic [1:0] r_item, r_chg, x_item, x_chg, gi, gc;
        logic       x_err, ge;
        legal  = plan != 2'b11 && (plan == 2'b00 || item == 2'b01 || item == 2'b10);
        paid   = plan == 2'b00 ? 20 : plan == 2'b01 ? 60 : 50;
        price  = plan == 2'b00 ? 20 : (item == 2'b01 ? 20 : 50);
        r_item = plan == 2'b00 ? ITEM_20 : item;
        r_chg  = chg_code(paid - price);
        n = 0;
        if (legal) begin
            e_sel[0] = 0; e_code[0] = plan == 2'b10 ? MONEY_50 : MONEY_10; n = 1;
            if (plan != 2'b10) begin e_sel[n] = 0; e_code[n] = plan == 2'b00 ? MONEY_10 : MONEY_50; n++; end
            if (plan != 2'b00) begin e_sel[n] = 1; e_code[n] = item; n++; end
        end
        if (!legal || md == M_SILENT) begin x_item = ITEM_NONE; x_chg = CHG_0; x_err = 1'b1; end
        else if (md == M_WRONG) begin
            x_item = r_item; x_chg = plan == 2'b00 ? r_chg : CHG_10; x_err = x_chg != r_chg;
        end else begin x_item = r_item; x_chg = r_chg; x_err = 1'b0; end
        mode = md;
        pq.delete();
        resp_cyc = -1;
        bus.req_plan  = plan;
        bus.req_item  = item;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;
        while (!bus.done && cyc < acc + 80) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout plan=%0d item=%0d mode=%0d: no done within 80 cycles", plan, item, md);
            return;
        end
        dc = cyc; gi = bus.got_item; gc = bus.got_change; ge = bus.err;
        exp_dc = !legal ? acc : md == M_SILENT ? acc + (n - 1) * (GAP + 1) + TIMEOUT : resp_cyc + 1;
        total++;
        if (dc !== exp_dc) begin
            bad++;
            $display("FAIL done_cycle plan=%0d item=%0d mode=%0d: got %0d exp %0d", plan, item, md, dc - acc, exp_dc - acc);
        end
        total++;
        if ({gi, gc, ge} !== {x_item, x_chg, x_err}) begin
            bad++;
            $display("FAIL result plan=%0d item=%0d mode=%0d: item/chg/err got %b/%b/%b exp %b/%b/%b",
                     plan, item, md, gi, gc, ge, x_item, x_chg, x_err);
        end
        @(posedge clk);
        #1;
        total++;
        if ({bus.done, bus.req_ready, bus.got_item, bus.got_change, bus.err} !== {1'b0, 1'b1, gi, gc, ge}) begin
            bad++;
            $display("FAIL after_done plan=%0d item=%0d: done/ready/item/chg/err got %b/%b/%b/%b/%b",
                     plan, item, bus.done, bus.req_ready, bus.got_item, bus.got_change, bus.err);
        end
        total++;
        if (pq.size() !== n) begin
            bad++;
            $display("FAIL pulse_count plan=%0d item=%0d: got %0d exp %0d", plan, item, pq.size(), n);
        end
        for (int i = 0; i < n && i < pq.size(); i++) begin
            total++;
            if ({pq[i].cyc - acc, pq[i].sel, 30'd0, pq[i].code} !== {i * (GAP + 1), e_sel[i], 30'd0, e_code[i]}) begin
                bad++;
                $display("FAIL pulse%0d plan=%0d: got at=%0d sel=%0d code=%b exp at=%0d sel=%0d code=%b",
                         i, plan, pq[i].cyc - acc, pq[i].sel, pq[i].code, i * (GAP + 1), e_sel[i], e_code[i]);
            end
        end
        total++;
        if ({overlaps, holds} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL pulse_shape: overlaps=%0d held=%0d exp 0/0", overlaps, holds);
        end
    endtask

    task automatic test_reset;
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b exp 1", bus.req_ready);
        end
        total++;
        if ({bus.money, bus.select, bus.done, bus.err, bus.got_item, bus.got_change} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs: money/sel/done/err/item/chg got %b/%b/%b/%b/%b/%b exp all 0",
                     bus.money, bus.select, bus.done, bus.err, bus.got_item, bus.got_change);
        end
    endtask

    task automatic test_plan00;
        test_purchase(2'b00, 2'($urandom_range(0, 3)), M_OK);
    endtask

    task automatic test_plan01;
        test_purchase(2'b01, 2'b01, M_OK);
    endtask

    task automatic test_plan10;
        test_purchase(2'b10, 2'b10, M_OK);
    endtask

    task automatic test_illegal;
        test_purchase(2'b11, 2'b01, M_OK);
        test_purchase(2'b10, 2'b00, M_OK);
        test_purchase(2'b01, 2'b11, M_OK);
    endtask

    task automatic test_timeout;
        test_purchase(2'b10, 2'b01, M_SILENT);
        test_purchase(2'b00, 2'b00, M_SILENT);
    endtask

    task automatic test_wrong_change;
        test_purchase(2'b10, 2'b01, M_WRONG);
    endtask

    task automatic test_reset_mid;
        int dn;
        mode = M_OK;
        bus.req_plan  = 2'b01;
        bus.req_item  = 2'b01;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.money, bus.select, bus.done, bus.req_ready} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_mid_outputs: money/sel/done/ready got %b/%b/%b/%b exp 00/00/0/1",
                     bus.money, bus.select, bus.done, bus.req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pq.delete();
        dn = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        total++;
        if ({dn, pq.size(), 31'd0, bus.req_ready} !== {32'd0, 32'd0, 31'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid_quiet: done=%0d pulses=%0d ready=%b exp 0/0/1", dn, pq.size(), bus.req_ready);
        end
        test_purchase(2'b01, 2'b10, M_OK);
    endtask

    task automatic test_random;
        int r;
        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 9);
            test_purchase(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          r < 7 ? M_OK : r < 9 ? M_WRONG : M_SILENT);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_plan  = 2'b00;
        bus.req_item  = 2'b00;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_plan00;
        test_plan01;
        test_plan10;
        test_illegal;
        test_timeout;
        test_wrong_change;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vending_buyer.md
Name: vending_buyer

Overview:
- Customer-side initiator for the vending_machine coin/select interface.
- Accepts a purchase request over a valid/ready handshake and drives one-cycle money and select pulses to the machine in protocol order.
- Waits for the machine's item/change response, checks it against the expected result, and reports the outcome.
- Sits between test/host logic and vending_machine; replaces hand-timed stimulus with a self-checking driver.

Parameters:
- GAP, 3: idle cycles between consecutive money/select pulses (min 1).
- TIMEOUT, 8: cycles allowed from the last driven pulse to a nonzero item before error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  purchase request valid.
- req_ready  output  1  high only in IDLE.
- req_plan  input  2  00 = 10+10, 01 = 10+50, 10 = 50, 11 = illegal.
- req_item  input  2  01 = item 20, 10 = item 50; ignored for plan 00.
- money  output  2  to vending_machine: 00 none, 01 = 10, 10 = 50.
- select  output  2  to vending_machine: 00 none, 01 = item 20, 10 = item 50.
- item  input  2  from vending_machine: 00 none, 01 = item 20, 10 = item 50.
- change  input  2  from vending_machine: 00 = 0, 01 = 10, 10 = 30, 11 = 40.
- done  output  1  one-cycle pulse at end of every accepted request.
- got_item  output  2  captured item, valid with done.
- got_change  output  2  captured change, valid with done.
- err  output  1  valid with done: illegal request, mismatch, or timeout.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - money, select, done, err, got_item, got_change all 00/0.
  - Timers cleared.
  - Reset mid-purchase aborts the purchase immediately; no done pulse is issued.
- Handshake:
  - Accept when req_valid && req_ready on a rising edge.
  - Latch plan and item; req_ready drops the next cycle.
- Illegal requests (plan 11, item 00 or 11 with plan != 00):
  - Go to DONE with err=1, got_item=00, got_change=00, no pulses driven.
  - done is asserted the cycle after accept.
- FSM states: IDLE -> COIN1 -> GAP1 -> [COIN2 -> GAP2] -> [SEL -> GAP3] -> WAIT -> DONE -> IDLE.
  - COIN1: money = 10 (01) for plan 00/01, 50 (10) for plan 10; exactly one cycle.
  - COIN2: plans 00/01 only; money = 01 (plan 00) or 10 (plan 01); one cycle.
  - SEL: plans 01/10 only; select = latched item for one cycle. Plan 00 skips SEL (machine auto-vends item 20).
  - GAPn: money = select = 00 for GAP cycles.
  - WAIT: starts after the final GAP. The timeout counter starts at the last pulse cycle.
  - Any cycle from the last pulse onward with item != 00 captures item/change in that cycle and goes to DONE.
  - Counter reaching TIMEOUT with no item also goes to DONE, with err=1.
  - A nonzero item seen during a GAP is captured immediately; remaining GAP and WAIT cycles are skipped.
- Expected results (mismatch in either field sets err=1):
  - plan 00 -> item 01, change 00.
  - plan 01 + item 01 -> item 01, change 11.
  - plan 01 + item 10 -> item 10, change 01.
  - plan 10 + item 01 -> item 01, change 10.
  - plan 10 + item 10 -> item 10, change 00.
- DONE: one cycle; done=1; got_*/err hold their values until the next accept. Returns to IDLE next cycle.
- money and select are registered, never nonzero simultaneously, and never held longer than one cycle.
- Total latency, legal plan 10 with GAP=3 and immediate response: accept, COIN1, 3 GAP, SEL, then item seen ≤ TIMEOUT cycles after SEL.

Optional Feature:
- Macro VENDING_BUYER_STATS_EN.
- Defined: adds outputs buy_count[7:0] and err_count[7:0].
  - Incremented in DONE for err=0 and err=1 requests respectively.
  - Saturate at 255; cleared by rst_n.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vending_pkg holds:
  - money codes (MONEY_NONE/10/50);
  - select/item codes (ITEM_NONE/20/50);
  - change codes (CHG_0/10/30/40);
  - plan codes;
  - the buyer state enum.
- vending_machine is retrofitted to import the same codes.
- One natural sub-module: vending_expect, a combinational plan/item -> expected item/change and legality decode.

Test Plan:
- Plan 00 against vending_machine -> money=01 twice, GAP=3 cycles apart; select never driven; done with got_item=01, got_change=00, err=0.
- Plan 01 with item 01 -> money 01, money 10, select 01 in sequence; done with got_item=01, got_change=11, err=0.
- Plan 10 with item 10 -> single money 10 then select 10; got_item=10, got_change=00, err=0.
- Plan 11, and separately plan 10 with item 00 -> no pulses; done one cycle after accept with err=1.
- Machine replaced by a stub that never responds -> done with err=1 exactly TIMEOUT cycles after the last pulse. Stub returning change 01 for plan 10/item 01 -> err=1, got_change=01.
- rst_n pulsed low during GAP1 of plan 01 -> outputs 00 immediately, no done pulse, req_ready=1 after release; next request completes normally.
